// File: rtl/ram_cmd_arbiter.sv
// ============================================================================
// Module   : ram_cmd_arbiter
// Brief    : Round-robin arbiter that lets two masters share the two-beat
//            command port of a 256x8 single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_cmd_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    output logic       m0_err,

    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       m1_err,

    output logic       busy,

    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid
);

    localparam int             CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  C_TIMEOUT   = CW'(TIMEOUT);
    localparam logic [1:0]     C_OP_WADDR  = 2'b00;
    localparam logic [1:0]     C_OP_WDATA  = 2'b01;
    localparam logic [1:0]     C_OP_RADDR  = 2'b10;
    localparam logic [1:0]     C_OP_RDATA  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    logic           r_last_grant;   // 0 = m0, 1 = m1
    logic           r_gnt;
    logic           r_we;
    logic [7:0]     r_addr;
    logic [7:0]     r_wdata;
    logic [CW-1:0]  r_cnt;

    logic           r_m0_ack;
    logic           r_m1_ack;
    logic           r_m0_err;
    logic           r_m1_err;
    logic [7:0]     r_m0_rdata;
    logic [7:0]     r_m1_rdata;
    logic           r_busy;
    logic [9:0]     r_ram_din;
    logic           r_ram_rx_valid;

    // m1 wins only when it is alone or m0 was the previous winner
    logic           w_pick_m1;
    logic           w_sel_we;
    logic [7:0]     w_sel_addr;
    logic [7:0]     w_sel_wdata;
    logic [CW-1:0]  w_cnt_inc;

    assign w_pick_m1   = m1_req & (~m0_req | ~r_last_grant);
    assign w_sel_we    = w_pick_m1 ? m1_we    : m0_we;
    assign w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
    assign w_cnt_inc   = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_gnt          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 8'h00;
            r_wdata        <= 8'h00;
            r_cnt          <= '0;
            r_m0_ack       <= 1'b0;
            r_m1_ack       <= 1'b0;
            r_m0_err       <= 1'b0;
            r_m1_err       <= 1'b0;
            r_m0_rdata     <= 8'h00;
            r_m1_rdata     <= 8'h00;
            r_busy         <= 1'b0;
            r_ram_din      <= 10'h000;
            r_ram_rx_valid <= 1'b0;
        end else begin
            r_m0_ack       <= 1'b0;
            r_m1_ack       <= 1'b0;
            r_m0_err       <= 1'b0;
            r_m1_err       <= 1'b0;
            r_ram_din      <= 10'h000;
            r_ram_rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_gnt          <= w_pick_m1;
                        r_last_grant   <= w_pick_m1;
                        r_we           <= w_sel_we;
                        r_addr         <= w_sel_addr;
                        r_wdata        <= w_sel_wdata;
                        r_busy         <= 1'b1;
                        r_ram_rx_valid <= 1'b1;
                        r_ram_din      <= {(w_sel_we ? C_OP_WADDR : C_OP_RADDR), w_sel_addr};
                        r_state        <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    r_ram_rx_valid <= 1'b1;
                    r_ram_din      <= r_we ? {C_OP_WDATA, r_wdata} : {C_OP_RDATA, 8'h00};
                    r_state        <= S_DATA;
                end

                S_DATA: begin
                    if (r_we) begin
                        if (r_gnt) r_m1_ack <= 1'b1;
                        else       r_m0_ack <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (ram_tx_valid) begin
                        if (r_gnt) begin
                            r_m1_ack   <= 1'b1;
                            r_m1_rdata <= ram_dout;
                        end else begin
                            r_m0_ack   <= 1'b1;
                            r_m0_rdata <= ram_dout;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // DONE lands exactly TIMEOUT cycles after WAIT entry
                        if (w_cnt_inc == C_TIMEOUT) begin
                            if (r_gnt) begin
                                r_m1_ack <= 1'b1;
                                r_m1_err <= 1'b1;
                            end else begin
                                r_m0_ack <= 1'b1;
                                r_m0_err <= 1'b1;
                            end
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ack       = r_m0_ack;
    assign m1_ack       = r_m1_ack;
    assign m0_err       = r_m0_err;
    assign m1_err       = r_m1_err;
    assign m0_rdata     = r_m0_rdata;
    assign m1_rdata     = r_m1_rdata;
    assign busy         = r_busy;
    assign ram_din      = r_ram_din;
    assign ram_rx_valid = r_ram_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
// ============================================================================
// Module   : tb_ram_cmd_arbiter
// Brief    : Self-checking bench for ram_cmd_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_cmd_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] m0_rdata, m1_rdata;
    logic       busy;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .busy(busy), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    typedef struct {
        bit         mst;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         resp;
        logic [9:0] exp_a;
        logic [9:0] exp_d;
        logic [7:0] exp_rd;
        bit         exp_err;
        int         exp_lat;   // cycles from address beat to ack
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    vec_t       sb0[$];
    vec_t       sb1[$];
    logic [9:0] beats[$];
    int         ack_log[$];
    int         cyc = 0;
    int         a_cyc = 0;
    logic [7:0] model_rd0 = 8'h00;
    logic [7:0] model_rd1 = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural RAM: answers a read one cycle after its 11 beat
    logic [7:0] mem [256];
    logic [7:0] ram_addr_q = 8'h00;
    bit         resp_en = 1'b1;
    bit         resp_pend = 1'b0;
    bit         spur = 1'b0;
    logic       r_resp = 1'b0;
    logic [7:0] r_rdout = 8'h00;

    assign ram_tx_valid = r_resp | spur;
    assign ram_dout     = r_rdout;

    always @(posedge clk) begin
        #1;
        r_resp    = resp_pend;
        r_rdout   = resp_pend ? mem[ram_addr_q] : 8'h00;
        resp_pend = 1'b0;
    end

    task automatic check_ack(input bit m);
        vec_t       e;
        logic [7:0] rd, ord, omodel;
        bit         er;
        if (m == 1'b0) begin
            if (sb0.size() == 0) begin chk("m0_unexpected_ack", 1, 0); return; end
            e = sb0.pop_front(); rd = m0_rdata; er = m0_err; ord = m1_rdata; omodel = model_rd1;
        end else begin
            if (sb1.size() == 0) begin chk("m1_unexpected_ack", 1, 0); return; end
            e = sb1.pop_front(); rd = m1_rdata; er = m1_err; ord = m0_rdata; omodel = model_rd0;
        end
        chk($sformatf("m%0d_beat_count", m), beats.size(), 2);
        if (beats.size() >= 2) begin
            chk($sformatf("m%0d_addr_beat", m), beats[0], e.exp_a);
            chk($sformatf("m%0d_data_beat", m), beats[1], e.exp_d);
        end
        chk($sformatf("m%0d_err", m), er, e.exp_err);
        chk($sformatf("m%0d_rdata", m), rd, e.exp_rd);
        chk($sformatf("m%0d_latency", m), cyc - a_cyc, e.exp_lat);
        chk($sformatf("m%0d_other_rdata", m), ord, omodel);
        if (m == 1'b0) model_rd0 = e.exp_rd;
        else           model_rd1 = e.exp_rd;
        ack_log.push_back(int'(m));
        beats.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            beats.delete();
            model_rd0 = 8'h00;
            model_rd1 = 8'h00;
        end else begin
            cyc++;
            if (ram_rx_valid) begin
                if (beats.size() == 0) a_cyc = cyc;
                beats.push_back(ram_din);
                case (ram_din[9:8])
                    2'b00, 2'b10: ram_addr_q = ram_din[7:0];
                    2'b01:        mem[ram_addr_q] = ram_din[7:0];
                    default:      resp_pend = resp_en;
                endcase
            end
            if (m0_ack && m1_ack) chk("ack_overlap", 1, 0);
            if (m0_ack) check_ack(1'b0);
            if (m1_ack) check_ack(1'b1);
        end
    end

    task automatic drive_m(input bit m, input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (m == 1'b0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
        else           begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic wait_ack(input bit m);
        bit got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = (m == 1'b0) ? m0_ack : m1_ack;
        end
        if (!got) chk($sformatf("m%0d_ack_wait_expired", m), 0, 1);
    endtask

    task automatic push_sb(input vec_t v);
        if (v.mst == 1'b0) sb0.push_back(v);
        else               sb1.push_back(v);
    endtask

    task automatic run_seq(input vec_t v);
        @(posedge clk); #1;
        resp_en = v.resp;
        push_sb(v);
        drive_m(v.mst, 1'b1, v.we, v.addr, v.wdata);
        wait_ack(v.mst);
        @(posedge clk); #1;
        drive_m(v.mst, 1'b0, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk("busy_after_ack", busy, 0);
        chk("ack_single_cycle", {m0_ack, m1_ack}, 0);
    endtask

    // Keeps req high across both transactions so the two masters contend
    task automatic master_drv(input bit m, input vec_t a, input vec_t b);
        push_sb(a);
        drive_m(m, 1'b1, a.we, a.addr, a.wdata);
        wait_ack(m);
        @(posedge clk); #1;
        push_sb(b);
        drive_m(m, 1'b1, b.we, b.addr, b.wdata);
        wait_ack(m);
        @(posedge clk); #1;
        drive_m(m, 1'b0, b.we, b.addr, b.wdata);
    endtask

    vec_t ctbl[4];
    vec_t tbl[8];
    vec_t mid;

    initial begin
        //            mst   we    addr   wdata  resp  exp_a     exp_d     exp_rd err   lat
        ctbl[0] = '{1'b0, 1'b1, 8'h40, 8'h11, 1'b1, 10'h040, 10'h111, 8'h00, 1'b0, 2};
        ctbl[1] = '{1'b1, 1'b1, 8'h41, 8'h22, 1'b1, 10'h041, 10'h122, 8'h00, 1'b0, 2};
        ctbl[2] = '{1'b0, 1'b0, 8'h41, 8'h00, 1'b1, 10'h241, 10'h300, 8'h22, 1'b0, 3};
        ctbl[3] = '{1'b1, 1'b0, 8'h40, 8'hEE, 1'b1, 10'h240, 10'h300, 8'h11, 1'b0, 3};

        tbl[0]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1, 10'h03C, 10'h1A5, 8'h22, 1'b0, 2};
        tbl[1]  = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 10'h23C, 10'h300, 8'hA5, 1'b0, 3};
        tbl[2]  = '{1'b1, 1'b1, 8'hFF, 8'h5A, 1'b1, 10'h0FF, 10'h15A, 8'hA5, 1'b0, 2};
        tbl[3]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 10'h2FF, 10'h300, 8'h5A, 1'b0, 3};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 10'h000, 10'h1C3, 8'h5A, 1'b0, 2};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 10'h200, 10'h300, 8'hC3, 1'b0, 3};
        tbl[6]  = '{1'b1, 1'b0, 8'h12, 8'h77, 1'b1, 10'h212, 10'h300, 8'h00, 1'b0, 3};
        tbl[7]  = '{1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 10'h23C, 10'h300, 8'h5A, 1'b1, 17};

        mid     = '{1'b0, 1'b1, 8'h77, 8'h99, 1'b1, 10'h077, 10'h199, 8'h00, 1'b0, 2};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        rst_n = 1'b0;
        drive_m(1'b0, 1'b1, 1'b1, 8'h01, 8'hFF);
        drive_m(1'b1, 1'b1, 1'b1, 8'h02, 8'hFF);
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
                                  busy, ram_din, ram_rx_valid}, 32'h0);
        end

        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_log.delete();
        fork
            master_drv(1'b0, ctbl[0], ctbl[2]);
            master_drv(1'b1, ctbl[1], ctbl[3]);
        join
        chk("grant_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), ack_log[i], i % 2);

        for (int i = 0; i < 8; i++) run_seq(tbl[i]);

        // Reset while a write sits in DATA; it must vanish and then rerun cleanly
        @(posedge clk); #1;
        resp_en = 1'b1;
        drive_m(1'b0, 1'b1, 1'b1, 8'h77, 8'h99);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midop_data_beat", {ram_rx_valid, ram_din}, {1'b1, 10'h199});
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_sb(mid);
        @(negedge clk);
        chk("midop_reset_idle", {busy, ram_rx_valid, ram_din, m0_ack, m1_ack, m0_rdata}, 0);
        wait_ack(1'b0);
        @(posedge clk); #1;
        drive_m(1'b0, 1'b0, 1'b1, 8'h77, 8'h99);
        @(negedge clk);
        chk("midop_busy_after", busy, 0);
        chk("midop_mem_written", mem[8'h77], 8'h99);

        // tx_valid outside WAIT must be ignored
        @(posedge clk); #1;
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_tx_ignored", {m0_ack, m1_ack, m0_err, m1_err, busy}, 0);
        end
        spur = 1'b0;
        chk("spurious_rdata_kept", {m0_rdata, m1_rdata}, {model_rd0, model_rd1});

        chk("scoreboard_drained", sb0.size() + sb1.size(), 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
